// File: rtl/dmem_responder.sv
// dmem_responder: byte-addressed RAM target with RISC-V load/store sizing and programmable wait states
module dmem_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              ready,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] a_q;
  logic [2:0]        f_q;
  logic [DATA_W-1:0] d_q, word, ld, st_data, mask;
  logic [15:0]       sh;
  logic [3:0]        be;
  logic              rd_q, wr_q, bad, access;
  logic [DATA_W-1:0] mem [2**(ADDR_W-2)];
  assign word    = mem[a_q[ADDR_W-1:2]];
  assign sh      = 16'(word >> {a_q[1:0], 3'b000});
  assign access  = (state == WAIT) && (cnt == 4'd0);
  // illegal combination, unknown size code, unsigned store, or misaligned half/word
  assign bad     = (rd_q & wr_q) | (f_q == 3'b011) | (f_q[2:1] == 2'b11) | (f_q[2] & wr_q)
                 | ((f_q[1:0] == 2'd1) & a_q[0]) | ((f_q[1:0] == 2'd2) & (|a_q[1:0]));
  assign ld      = f_q == 3'b000 ? {{24{sh[7]}}, sh[7:0]} :
                   f_q == 3'b001 ? {{16{sh[15]}}, sh} :
                   f_q == 3'b100 ? {24'd0, sh[7:0]} :
                   f_q == 3'b101 ? {16'd0, sh} : word;
  assign be      = f_q[1:0] == 2'd0 ? 4'b0001 << a_q[1:0] :
                   f_q[1:0] == 2'd1 ? 4'b0011 << a_q[1:0] : 4'b1111;
  assign mask    = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign st_data = f_q[1:0] == 2'd0 ? {4{d_q[7:0]}} :
                   f_q[1:0] == 2'd1 ? {2{d_q[15:0]}} : d_q;
  // RAM is deliberately outside the reset domain so contents survive reset
  always_ff @(posedge clk)
    if (reset && access && wr_q && !bad) mem[a_q[ADDR_W-1:2]] <= (word & ~mask) | (st_data & mask);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rd_data <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
      a_q     <= '0;
      f_q     <= 3'd0;
      d_q     <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
          err   <= 1'b0;
          if (rd | wr) begin
            a_q   <= addr;
            f_q   <= funct3;
            d_q   <= wr_data;
            rd_q  <= rd;
            wr_q  <= wr;
            cnt   <= 4'(WAIT_CYCLES);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else begin
            state   <= RESP;
            ready   <= 1'b1;
            err     <= bad;
            rd_data <= bad ? '0 : rd_q ? ld : rd_data;
          end
        end
        RESP: begin
          state <= IDLE;
          ready <= 1'b0;
          err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
